// File: rtl/mskaes_ks_round_ctrl.sv
// Round sequencer for the masked AES-128 key schedule.
// Loads the cipher key sharing and launches the masked S-box on RotWord once
// per round. It steers the rcon sharing generator through rcon_rst,
// rcon_update and rcon_mask, and presents each round key 0..NROUNDS on a
// valid/ready handshake.
// Optional feature: define MSKAES_KS_ABORT_EN to add a synchronous abort input.
//
// Handshake semantics: a transfer happens in a cycle where valid and ready are
// both high. in_valid/in_ready transfer a cipher key into the controller.
// out_valid/out_ready transfer the current round key to the consumer.
// Once out_valid is high it stays high until the transfer happens, and the
// round key does not change while it waits.
// Ready never depends combinationally on valid.
module mskaes_ks_round_ctrl #(
    parameter int d        = 2,
    parameter int SBOX_LAT = 4,
    parameter int NROUNDS  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       key_load,
    output logic       sbox_start,
    output logic       key_upd,
    output logic       rcon_rst,
    output logic       rcon_update,
    output logic       rcon_mask,
    output logic [3:0] round,
    output logic       last_round,
    output logic       out_valid,
`ifdef MSKAES_KS_ABORT_EN
    input  logic       abort,
`endif
    input  logic       out_ready
);

    localparam int CW = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SBOX_LAT - 1);
    localparam logic [3:0]    ROUND_LAST = 4'(NROUNDS);

    if (SBOX_LAT < 1 || d < 1) begin : g_bad_params
        $error("mskaes_ks_round_ctrl: SBOX_LAT and d must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, LOAD, PRESENT, SBOX} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    round_nxt;
    logic          rst_flag;
    logic          abort_act;

`ifdef MSKAES_KS_ABORT_EN
    assign abort_act = abort && (state != IDLE);
`else
    assign abort_act = 1'b0;
`endif

    assign last_round = (round == ROUND_LAST);

    // State, wait counter and round index; rst_flag keeps rcon_rst high for
    // the first cycle after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            round    <= 4'd0;
            rst_flag <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            round    <= round_nxt;
            rst_flag <= 1'b0;
        end
    end

    // Next-state and output decode from registered state only; out_ready only
    // steers the next state.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        round_nxt   = round;
        in_ready    = 1'b0;
        key_load    = 1'b0;
        sbox_start  = 1'b0;
        key_upd     = 1'b0;
        rcon_rst    = rst_flag;
        rcon_update = 1'b0;
        rcon_mask   = 1'b0;
        out_valid   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = LOAD;
            end
            LOAD: begin
                key_load  = 1'b1;
                rcon_rst  = 1'b1;
                round_nxt = 4'd0;
                state_nxt = PRESENT;
            end
            PRESENT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (last_round) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = SBOX;
                        cnt_nxt   = '0;
                    end
                end
            end
            SBOX: begin
                sbox_start = (cnt == '0);
                cnt_nxt    = cnt + CW'(1);
                if (cnt == CNT_LAST) begin
                    // The current rcon is XORed in now; the generator
                    // advances to the next rcon on this same edge.
                    key_upd     = 1'b1;
                    rcon_mask   = 1'b1;
                    rcon_update = 1'b1;
                    if (!last_round) round_nxt = round + 4'd1;
                    state_nxt   = PRESENT;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Abort wins over every transition, including the key update cycle.
        if (abort_act) begin
            state_nxt   = IDLE;
            round_nxt   = round;
            key_upd     = 1'b0;
            sbox_start  = 1'b0;
            rcon_update = 1'b0;
            rcon_mask   = 1'b0;
            rcon_rst    = 1'b1;
        end
    end

endmodule

// File: tb/tb_mskaes_ks_round_ctrl.sv
// Directed bench for mskaes_ks_round_ctrl (SBOX_LAT=4, NROUNDS=10).
// It holds a small model of the upstream rcon sharing generator, so the rcon
// consumed at each key update can be checked against the AES rcon table.
module tb_mskaes_ks_round_ctrl;

    logic       clk, rst;
    logic       in_valid, in_ready, key_load, sbox_start, key_upd;
    logic       rcon_rst, rcon_update, rcon_mask;
    logic [3:0] round;
    logic       last_round, out_valid, out_ready;
`ifdef MSKAES_KS_ABORT_EN
    logic       abort;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rcon_tab [1:10];
    logic [7:0] rcon_val;
    logic [7:0] rcon_share;

    mskaes_ks_round_ctrl #(.d(2), .SBOX_LAT(4), .NROUNDS(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .key_load(key_load), .sbox_start(sbox_start), .key_upd(key_upd),
        .rcon_rst(rcon_rst), .rcon_update(rcon_update), .rcon_mask(rcon_mask),
        .round(round), .last_round(last_round), .out_valid(out_valid),
`ifdef MSKAES_KS_ABORT_EN
        .abort(abort),
`endif
        .out_ready(out_ready)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // rcon generator model: reset to 0x01, xtime on update, masked output
    always @(posedge clk) begin
        if (rcon_rst) rcon_val <= 8'h01;
        else if (rcon_update) rcon_val <= {rcon_val[6:0], 1'b0} ^ (rcon_val[7] ? 8'h1b : 8'h00);
    end
    assign rcon_share = rcon_mask ? rcon_val : 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One key from accept to the last round key. A backpressure window of
    // bp_cycles is applied at round bp_round; noisy drives in_valid mid-run.
    task automatic run_key(input int bp_round, input int bp_cycles, input bit noisy);
        int  c, k, n_load, n_stray, extra;
        bit  done, bp_done;
        logic [7:0] exp;
        c = 0; k = 0; n_load = 0; n_stray = 0; done = 0; bp_done = 0;
        extra = (bp_round < 10) ? bp_cycles : 0;
        exp_q.delete();
        for (int i = 1; i <= 10; i++) exp_q.push_back(rcon_tab[i]);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (!done && c < 400) begin
            @(negedge clk);
            c++;
            in_valid = noisy && (c >= 10) && (c < 40);
            if (c == 1) begin
                check("load_pulse", key_load, 1);
                check("load_rcon_rst", rcon_rst, 1);
            end
            if (key_load) n_load++;
            if (rcon_mask && !key_upd) n_stray++;
            if (key_upd) begin
                k++;
                check("upd_cycle", c, 1 + 5*k + ((k > bp_round) ? bp_cycles : 0));
                check("upd_round", round, k - 1);
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                check("rcon", rcon_share, exp);
            end
            if (out_valid && round == 4'(bp_round) && !bp_done) begin
                bp_done   = 1;
                out_ready = 1'b0;
                for (int i = 0; i < bp_cycles; i++) begin
                    @(negedge clk);
                    c++;
                    if (key_load) n_load++;
                    check("bp_valid", out_valid, 1);
                    check("bp_round", round, bp_round);
                    check("bp_sbox", sbox_start, 0);
                    check("bp_rcon", rcon_val, rcon_tab[bp_round + 1]);
                end
                out_ready = 1'b1;
            end
            if (out_valid && last_round) begin
                check("last_cycle", c, 52 + extra);
                check("last_round_idx", round, 10);
                done = 1;
            end
        end
        if (!done) check("run_timeout", 0, 1);
        check("upd_count", k, 10);
        check("load_count", n_load, 1);
        check("rcon_idle_zero", n_stray, 0);
        check("exp_q_empty", exp_q.size(), 0);
        @(negedge clk);
        check("back_idle", in_ready, 1);
        check("back_no_valid", out_valid, 0);
    endtask

    // stimulus and final report
    initial begin
        rcon_tab[1] = 8'h01; rcon_tab[2] = 8'h02; rcon_tab[3] = 8'h04; rcon_tab[4] = 8'h08;
        rcon_tab[5] = 8'h10; rcon_tab[6] = 8'h20; rcon_tab[7] = 8'h40; rcon_tab[8] = 8'h80;
        rcon_tab[9] = 8'h1b; rcon_tab[10] = 8'h36;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
`ifdef MSKAES_KS_ABORT_EN
        abort = 1'b0;
`endif
        // reset state
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_rcon_rst", rcon_rst, 1);
        check("rst_round", round, 0);
        check("rst_key_load", key_load, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("rel_rcon_rst_hold", rcon_rst, 1);
        @(negedge clk);
        check("rel_rcon_rst_clear", rcon_rst, 0);

        // full run, then backpressure with a noisy in_valid, then a fresh key
        run_key(99, 0, 1'b0);
        run_key(3, 7, 1'b1);
        run_key(99, 0, 1'b0);

        // async reset mid-SBOX at round 6
        begin
            int w;
            in_valid = 1'b1; out_ready = 1'b1;
            w = 0;
            @(negedge clk);
            in_valid = 1'b0;
            while (!(round == 4'd6 && sbox_start) && w < 200) begin
                @(negedge clk);
                w++;
            end
            check("reach_round6", (w < 200), 1);
            @(negedge clk);
            #2 rst = 1'b1;
            #1;
            check("arst_out_valid", out_valid, 0);
            check("arst_in_ready", in_ready, 1);
            check("arst_round", round, 0);
            check("arst_rcon_rst", rcon_rst, 1);
            check("arst_sbox", {sbox_start, key_upd, rcon_mask}, 0);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            run_key(99, 0, 1'b0);
        end

`ifdef MSKAES_KS_ABORT_EN
        // abort in the key update cycle that would produce round 2
        begin
            int w;
            in_valid = 1'b1; out_ready = 1'b1;
            w = 0;
            @(negedge clk);
            in_valid = 1'b0;
            while (!(round == 4'd1 && sbox_start) && w < 200) begin
                @(negedge clk);
                w++;
            end
            check("reach_round1", (w < 200), 1);
            repeat (3) @(negedge clk);
            abort = 1'b1;
            #1;
            check("abort_key_upd", key_upd, 0);
            check("abort_rcon_update", rcon_update, 0);
            check("abort_rcon_mask", rcon_mask, 0);
            check("abort_rcon_rst", rcon_rst, 1);
            @(negedge clk);
            abort = 1'b0;
            check("abort_idle", in_ready, 1);
            run_key(99, 0, 1'b0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
